// File: rtl/cpu_ram_arbiter.sv
// Round-robin arbiter letting two masters share one single-port word RAM.
// One RAM access per grant; a wait-state counter retires accesses the RAM never answers.
module cpu_ram_arbiter #(
  parameter int AW      = 15,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic [31:0]   m0_rdata,
  output logic          m0_ready,
  output logic          m0_err,
  input  logic          m1_valid,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic [31:0]   m1_rdata,
  output logic          m1_ready,
  output logic          m1_err,
  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic       r_grant;
  logic       r_last_grant;
  logic [7:0] r_tmo_cnt;

  logic w_busy;
  logic w_tmo_hit;
  logic w_done;
  logic w_err;

  assign w_busy    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
  assign w_done    = (r_state == S_WAIT) && (mem_ready || w_tmo_hit);
  assign w_err     = (r_state == S_WAIT) && !mem_ready && w_tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_tmo_cnt    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_valid || m1_valid) begin
            r_state   <= S_ISSUE;
            r_tmo_cnt <= 8'd0;
            // Only a tie moves the round-robin pointer; a lone requester just wins.
            if (m0_valid && m1_valid) begin
              r_grant      <= ~r_last_grant;
              r_last_grant <= ~r_last_grant;
            end else begin
              r_grant <= m1_valid;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready || w_tmo_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Request fields come straight from the granted master, which holds them until ready.
  assign mem_valid = (r_state == S_ISSUE);
  assign mem_addr  = !w_busy ? '0    : (r_grant ? m1_addr  : m0_addr);
  assign mem_wdata = !w_busy ? 32'd0 : (r_grant ? m1_wdata : m0_wdata);
  assign mem_wstrb = !w_busy ? 4'd0  : (r_grant ? m1_wstrb : m0_wstrb);

  assign m0_ready = w_done && !r_grant;
  assign m1_ready = w_done &&  r_grant;
  assign m0_err   = w_err  && !r_grant;
  assign m1_err   = w_err  &&  r_grant;

  assign m0_rdata = m0_err ? 32'hDEADBEEF : mem_rdata;
  assign m1_rdata = m1_err ? 32'hDEADBEEF : mem_rdata;

endmodule
